// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: n-bit signed/unsigned operands, full 2n-bit product
// as hi/lo, one adder stepped over n cycles behind a start/busy/done handshake.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sign,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int CW = $clog2(n + 1);

  mul_state_e      state, state_nxt;
  logic [2*n:0]    acc;
  logic [n-1:0]    mcand;
  logic            neg;
  logic [CW-1:0]   count;

  logic            accept, last_step;
  logic            as_op, bs_op;
  logic [n-1:0]    a_mag, b_mag;
  logic [n:0]      sum;
  logic [2*n:0]    step_acc;
  logic [2*n-1:0]  prod_fix;

  // Two's-complement negate used both for operand magnitudes and for the final sign fixup.
  function automatic logic [2*n-1:0] cond_neg(input logic en, input logic [2*n-1:0] v);
    return en ? (~v + {{(2*n-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign accept    = start && ((state == MUL_IDLE) || (state == MUL_DONE));
  assign last_step = (state == MUL_RUN) && (count == CW'(1));

  assign as_op = sign & a[n-1];
  assign bs_op = sign & b[n-1];
  assign a_mag = n'(cond_neg(as_op, {{n{1'b0}}, a}));
  assign b_mag = n'(cond_neg(bs_op, {{n{1'b0}}, b}));

  assign sum      = acc[2*n:n] + {1'b0, mcand};
  assign step_acc = acc[0] ? ({sum, acc[n-1:0]} >> 1) : (acc >> 1);
  assign prod_fix = cond_neg(neg, step_acc[2*n-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (count == CW'(1)) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL_RUN);
    done = (state == MUL_DONE);
  end

  // Accept captures magnitudes; each RUN cycle is one conditional add plus shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      acc   <= {1'b0, {n{1'b0}}, b_mag};
      mcand <= a_mag;
      neg   <= as_op ^ bs_op;
      count <= CW'(n);
    end else if (state == MUL_RUN) begin
      acc   <= step_acc;
      count <= count - CW'(1);
      if (last_step) {hi, lo} <= prod_fix;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: constant vectors and handshake sequences at n=8, random pairs at n=16.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sign8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        start16, sign16, busy16, done16;
  logic [15:0] a16, b16, hi16, lo16;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  seq_multiplier #(.n(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sign(sign8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  seq_multiplier #(.n(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sign(sign16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mathematical product of w-bit operands, reduced to 2w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [15:0] p;
    int done_cyc, busy_cnt;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sign8 = s;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sign8 = 1'($urandom);
    done_cyc = -1; busy_cnt = 0; p = '0;
    for (int k = 1; k <= 30 && done_cyc < 0; k++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cyc = k;
        p = {hi8, lo8};
      end else begin
        @(negedge clk);
      end
    end
    check({tag, " product"}, {16'h0, p}, ref_prod(8, {8'h0, a}, {8'h0, b}, s));
    check({tag, " done cycle"}, done_cyc, 9);
    check({tag, " busy cycles"}, busy_cnt, 8);
    @(negedge clk);
    check({tag, " done width"}, {31'h0, done8}, 0);
    check({tag, " result hold"}, {16'h0, hi8, lo8}, {16'h0, p});
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic s, input int idx);
    logic [31:0] p;
    int done_cyc;
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; sign16 = s;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    done_cyc = -1; p = '0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      if (done16) begin
        done_cyc = k;
        p = {hi16, lo16};
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("rand16[%0d] s=%0b %h*%h", idx, s, a, b), p, ref_prod(16, a, b, s));
    check($sformatf("rand16[%0d] done cycle", idx), done_cyc, 17);
  endtask

  initial begin
    int d1, d2, dcount;
    logic [15:0] p1, p2;

    vecs[0]  = '{8'd13,  8'd11,  1'b0, 16'h008F};
    vecs[1]  = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
    vecs[2]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[4]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[5]  = '{8'h00,  8'hFF,  1'b0, 16'h0000};
    vecs[6]  = '{8'h80,  8'hFF,  1'b0, 16'h7F80};
    vecs[7]  = '{8'h80,  8'hFF,  1'b1, 16'h0080};
    vecs[8]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    vecs[9]  = '{8'hFD,  8'h05,  1'b0, 16'h04F1};
    vecs[10] = '{8'h80,  8'h80,  1'b0, 16'h4000};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; sign8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; sign16 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy8", {31'h0, busy8}, 0);
    check("reset done8", {31'h0, done8}, 0);
    check("reset hilo8", {16'h0, hi8, lo8}, 0);
    check("reset busy16", {31'h0, busy16}, 0);
    check("reset hilo16", {hi16, lo16}, 0);
    rst_n = 1'b1;

    // Constant vectors
    for (int i = 0; i < 11; i++) begin
      logic [15:0] got;
      @(negedge clk);
      start8 = 1'b1; a8 = vecs[i].a; b8 = vecs[i].b; sign8 = vecs[i].s;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      got = 16'hDEAD;
      for (int k = 1; k <= 30; k++) begin
        if (done8) begin
          got = {hi8, lo8};
          check($sformatf("vec%0d done cycle", i), k, 9);
          break;
        end
        check($sformatf("vec%0d busy c%0d", i, k), {31'h0, busy8}, 1);
        @(negedge clk);
      end
      check($sformatf("vec%0d product", i), {16'h0, got}, {16'h0, vecs[i].exp});
    end

    // Start held high: back-to-back results, operands changed during RUN
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd3; sign8 = 1'b0;
    d1 = -1; d2 = -1; p1 = '0; p2 = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin a8 = 8'd7; b8 = 8'd9; end
      if (done8) begin
        if (d1 < 0) begin d1 = k; p1 = {hi8, lo8}; end
        else if (d2 < 0) begin d2 = k; p2 = {hi8, lo8}; start8 = 1'b0; end
      end
    end
    check("b2b first done cycle", d1, 9);
    check("b2b first product", {16'h0, p1}, 6);
    check("b2b second done cycle", d2, 18);
    check("b2b second product", {16'h0, p2}, 63);
    check("b2b idle after", {31'h0, busy8}, 0);

    // start pulses in RUN are ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd13; b8 = 8'd11; sign8 = 1'b0;
    dcount = 0; d1 = -1; p1 = '0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start8 = (k == 3 || k == 6);
      if (start8) begin a8 = 8'hFF; b8 = 8'hFF; sign8 = 1'b1; end
      if (done8) begin
        dcount++;
        if (d1 < 0) begin d1 = k; p1 = {hi8, lo8}; end
      end
    end
    check("ignore-start done cycle", d1, 9);
    check("ignore-start product", {16'h0, p1}, 32'h008F);
    check("ignore-start done count", dcount, 1);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd6; sign8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'h0, busy8}, 0);
    check("abort done", {31'h0, done8}, 0);
    check("abort hilo", {16'h0, hi8, lo8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done8 || busy8) dcount++;
    end
    check("abort no done", dcount, 0);
    mul8(8'd13, 8'd11, 1'b0, "after abort");

    for (int i = 0; i < 200; i++)
      mul8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand8[%0d]", i));

    for (int i = 0; i < 1000; i++)
      mul16(16'($urandom), 16'($urandom), 1'($urandom), i);
    mul16(16'h8000, 16'h8000, 1'b1, 1000);
    mul16(16'hFFFF, 16'hFFFF, 1'b0, 1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
